// File: rtl/sap_controller_if.sv
// sap_controller_if: control bus between the SAP sequencer and its datapath.
// master (sequencer): opcode, debug in; T-state ring, enables, load strobes,
//                     halt out.
// slave  (datapath) : mirror image of master.
interface sap_controller_if #(
    parameter int OPC_W = 4
);
    logic [OPC_W-1:0] opcode;
    logic             debug;
    logic [5:0]       tstate;
    logic             pc_inc;
    logic             pc_out;
    logic             mar_load;
    logic             ram_out;
    logic             ir_load;
    logic             ir_out;
    logic             a_load;
    logic             a_out;
    logic             b_load;
    logic             out_load;
    logic             alu_sub;
    logic             alu_out;
    logic             halt;

    modport master (
        input  opcode, debug,
        output tstate, pc_inc, pc_out, mar_load, ram_out, ir_load, ir_out,
               a_load, a_out, b_load, out_load, alu_sub, alu_out, halt
    );

    modport slave (
        output opcode, debug,
        input  tstate, pc_inc, pc_out, mar_load, ram_out, ir_load, ir_out,
               a_load, a_out, b_load, out_load, alu_sub, alu_out, halt
    );
endinterface

// File: rtl/sap_controller.sv
// sap_controller: T-state sequencer for the 8-bit SAP CPU.
// Ports:
//   i_clk    system clock
//   i_reset  asynchronous, active-high reset
//   bus      sap_controller_if.master: opcode/debug in; one-hot tstate
//            (bit0=T1, 0=idle), bus enables, load strobes, halt out
//
// state | meaning
// IDLE  | post-reset, first clock enters T1
// T1    | Ep, Lm      (PC -> MAR)
// T2    | Cp          (PC increment)
// T3    | CE, Li      (RAM -> IR); opcode sampled on exit
// T4    | execute 1   (frozen here when halted)
// T5    | execute 2
// T6    | execute 3
module sap_controller #(
    parameter int             OPC_W   = 4,
    parameter logic [OPC_W-1:0] OPC_LDA = OPC_W'('h0),
    parameter logic [OPC_W-1:0] OPC_ADD = OPC_W'('h1),
    parameter logic [OPC_W-1:0] OPC_SUB = OPC_W'('h2),
    parameter logic [OPC_W-1:0] OPC_OUT = OPC_W'('hE),
    parameter logic [OPC_W-1:0] OPC_HLT = OPC_W'('hF)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    sap_controller_if.master  bus
);

    typedef enum logic [5:0] {
        S_IDLE = 6'b000000,
        S_T1   = 6'b000001,
        S_T2   = 6'b000010,
        S_T3   = 6'b000100,
        S_T4   = 6'b001000,
        S_T5   = 6'b010000,
        S_T6   = 6'b100000
    } state_t;

    // enable order: {pc_inc, pc_out, ram_out, ir_out, a_out, alu_sub, alu_out}
    localparam logic [6:0] EN_CP = 7'b1000000;
    localparam logic [6:0] EN_EP = 7'b0100000;
    localparam logic [6:0] EN_CE = 7'b0010000;
    localparam logic [6:0] EN_EI = 7'b0001000;
    localparam logic [6:0] EN_EA = 7'b0000100;
    localparam logic [6:0] EN_SU = 7'b0000010;
    localparam logic [6:0] EN_EU = 7'b0000001;

    // load order: {mar_load, ir_load, a_load, b_load, out_load}
    localparam logic [4:0] LD_LM = 5'b10000;
    localparam logic [4:0] LD_LI = 5'b01000;
    localparam logic [4:0] LD_LA = 5'b00100;
    localparam logic [4:0] LD_LB = 5'b00010;
    localparam logic [4:0] LD_LO = 5'b00001;

    state_t           state_q, state_d;
    logic [OPC_W-1:0] opc_q, opc_d;
    logic             halt_q, halt_d;
    logic [6:0]       en_q, en_d;
    logic [4:0]       ld_now;
    logic [4:0]       ld_tog_n, ld_tog_p;
    logic             debug_unused;

    function automatic logic is_mem(logic [OPC_W-1:0] opc);
        return (opc == OPC_LDA) || (opc == OPC_ADD) || (opc == OPC_SUB);
    endfunction

    function automatic logic is_alu(logic [OPC_W-1:0] opc);
        return (opc == OPC_ADD) || (opc == OPC_SUB);
    endfunction

    function automatic logic [6:0] decode_en(state_t s, logic [OPC_W-1:0] opc,
                                             logic halted);
        logic [6:0] e;
        e = '0;
        case (s)
            S_T1: e = EN_EP;
            S_T2: e = EN_CP;
            S_T3: e = EN_CE;
            S_T4: if (!halted) begin
                if (is_mem(opc))         e = EN_EI;
                else if (opc == OPC_OUT) e = EN_EA;
            end
            S_T5: if (is_mem(opc)) e = EN_CE;
            S_T6: if (is_alu(opc)) e = EN_EU | ((opc == OPC_SUB) ? EN_SU : 7'b0);
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic logic [4:0] decode_ld(state_t s, logic [OPC_W-1:0] opc,
                                             logic halted);
        logic [4:0] l;
        l = '0;
        case (s)
            S_T1: l = LD_LM;
            S_T3: l = LD_LI;
            S_T4: if (!halted) begin
                if (is_mem(opc))         l = LD_LM;
                else if (opc == OPC_OUT) l = LD_LO;
            end
            S_T5: begin
                if (opc == OPC_LDA)  l = LD_LA;
                else if (is_alu(opc)) l = LD_LB;
            end
            S_T6: if (is_alu(opc)) l = LD_LA;
            default: l = '0;
        endcase
        return l;
    endfunction

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= S_IDLE;
            opc_q    <= '0;
            halt_q   <= 1'b0;
            en_q     <= '0;
            ld_tog_p <= '0;
        end else begin
            state_q  <= state_d;
            opc_q    <= opc_d;
            halt_q   <= halt_d;
            en_q     <= en_d;
            ld_tog_p <= ld_tog_n;
        end
    end

    // Strobes are toggle-encoded across both edges: the negedge flop flips
    // to raise a strobe mid-state, the posedge flop catches up to drop it,
    // so each strobe is high exactly from negedge to the following posedge.
    always_ff @(negedge i_clk or posedge i_reset) begin
        if (i_reset) ld_tog_n <= '0;
        else         ld_tog_n <= ld_tog_n ^ ld_now;
    end

    always_comb begin
        state_d = state_q;
        opc_d   = opc_q;
        halt_d  = halt_q;
        if (!halt_q) begin
            case (state_q)
                S_IDLE: state_d = S_T1;
                S_T1:   state_d = S_T2;
                S_T2:   state_d = S_T3;
                S_T3: begin
                    state_d = S_T4;
                    opc_d   = bus.opcode;
                    halt_d  = (bus.opcode == OPC_HLT);
                end
                S_T4:   state_d = S_T5;
                S_T5:   state_d = S_T6;
                S_T6:   state_d = S_T1;
                default: state_d = S_IDLE;
            endcase
        end
        // Enables are registered for the state being entered; strobes are
        // decoded from the state currently held.
        en_d   = decode_en(state_d, opc_d, halt_d);
        ld_now = decode_ld(state_q, opc_q, halt_q);
    end

    // Trace enable has no effect in hardware.
    assign debug_unused = bus.debug;

    assign bus.tstate = state_q;
    assign bus.halt   = halt_q;
    assign {bus.pc_inc, bus.pc_out, bus.ram_out, bus.ir_out,
            bus.a_out, bus.alu_sub, bus.alu_out} = en_q;
    assign {bus.mar_load, bus.ir_load, bus.a_load,
            bus.b_load, bus.out_load} = ld_tog_n ^ ld_tog_p;

endmodule

// File: tb/tb_sap_controller.sv
module tb_sap_controller;

    logic i_clk = 1'b0;
    logic i_reset;

    sap_controller_if #(.OPC_W(4)) bus ();

    sap_controller #(.OPC_W(4)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    always #5 i_clk = ~i_clk;

    // signal vector bit positions
    localparam logic [11:0] CP = 12'h800, EP = 12'h400, LM = 12'h200,
                            CE = 12'h100, LI = 12'h080, EI = 12'h040,
                            LA = 12'h020, EA = 12'h010, LB = 12'h008,
                            LO = 12'h004, SU = 12'h002, EU = 12'h001;
    localparam logic [11:0] LD_MASK = LM | LI | LA | LB | LO;

    typedef struct packed {
        logic [5:0]  ts;
        logic        halt;
        logic [11:0] sig;
    } rec_t;

    rec_t sb[$];
    rec_t cur;
    bit   cur_valid = 0;
    int   checks = 0;
    int   failures = 0;

    function automatic logic [11:0] sig_vec();
        return {bus.pc_inc, bus.pc_out, bus.mar_load, bus.ram_out, bus.ir_load,
                bus.ir_out, bus.a_load, bus.a_out, bus.b_load, bus.out_load,
                bus.alu_sub, bus.alu_out};
    endfunction

    task automatic check(string name, logic [11:0] act, logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Microprogram of the SAP-1: what each T-state of each instruction does.
    function automatic rec_t model(int t, logic [3:0] opc);
        rec_t r;
        r.ts   = 6'(1 << (t - 1));
        r.halt = (opc == 4'hF) && (t == 4);
        r.sig  = '0;
        case (t)
            1: r.sig = EP | LM;
            2: r.sig = CP;
            3: r.sig = CE | LI;
            4: case (opc)
                   4'h0, 4'h1, 4'h2: r.sig = EI | LM;
                   4'hE:             r.sig = EA | LO;
                   default:          r.sig = '0;
               endcase
            5: case (opc)
                   4'h0:       r.sig = CE | LA;
                   4'h1, 4'h2: r.sig = CE | LB;
                   default:    r.sig = '0;
               endcase
            6: case (opc)
                   4'h1:    r.sig = EU | LA;
                   4'h2:    r.sig = EU | SU | LA;
                   default: r.sig = '0;
               endcase
            default: r.sig = '0;
        endcase
        return r;
    endfunction

    // Monitor: each posedge presents a new T-state.
    always @(posedge i_clk) begin
        #1;
        if (!i_reset) begin
            if (sb.size() > 0) begin
                cur = sb.pop_front();
                cur_valid = 1;
                check("tstate", 12'(bus.tstate), 12'(cur.ts));
                check("halt", 12'(bus.halt), 12'(cur.halt));
                check("enables_after_posedge", sig_vec(), cur.sig & ~LD_MASK);
            end else if (bus.tstate != 6'd0) begin
                cur_valid = 0;
                check("unexpected_tstate", 12'(bus.tstate), 12'd0);
            end
        end
    end

    always @(negedge i_clk) begin
        #1;
        if (!i_reset && cur_valid)
            check("strobes_mid_state", sig_vec(), cur.sig);
    end

    // Reset asserted after the mid-state negedge, held across one posedge,
    // released on a negedge.
    task automatic do_reset();
        #7;
        i_reset = 1'b1;
        sb.delete();
        cur_valid = 0;
        #1;
        check("reset_outputs", sig_vec(), 12'd0);
        check("reset_tstate", 12'(bus.tstate), 12'd0);
        check("reset_halt", 12'(bus.halt), 12'd0);
        @(posedge i_clk);
        #1;
        check("reset_hold_tstate", 12'(bus.tstate), 12'd0);
        @(negedge i_clk);
        i_reset = 1'b0;
    endtask

    // Called at a negedge just before the posedge that enters T1.
    task automatic run_instr(logic [3:0] opc, bit rst_t5);
        int n;
        n = (opc == 4'hF) ? 4 : 6;
        for (int k = 1; k <= n; k++) sb.push_back(model(k, opc));
        if (opc == 4'hF)
            for (int j = 0; j < 20; j++) sb.push_back(model(4, opc));
        for (int k = 1; k <= 6; k++) begin
            bus.opcode = (k == 4) ? opc : 4'($urandom);
            @(posedge i_clk);
            if (opc == 4'hF && k == 4) begin
                for (int j = 0; j < 20; j++) begin
                    @(negedge i_clk);
                    bus.opcode = 4'($urandom);
                    @(posedge i_clk);
                end
                do_reset();
                return;
            end
            if (rst_t5 && k == 5) begin
                do_reset();
                return;
            end
            @(negedge i_clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] opc;
        int         r;
        bit         rst;

        i_reset    = 1'b1;
        bus.opcode = 4'h0;
        bus.debug  = 1'($urandom);
        #1;
        check("initial_reset_outputs", sig_vec(), 12'd0);
        check("initial_reset_tstate", 12'(bus.tstate), 12'd0);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b0;

        run_instr(4'h0, 0);
        run_instr(4'h2, 0);
        run_instr(4'hE, 0);
        run_instr(4'h7, 0);
        run_instr(4'h1, 1);
        run_instr(4'h0, 0);
        run_instr(4'hF, 0);
        run_instr(4'h1, 0);

        repeat (40) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1:    opc = 4'h0;
                2, 3:    opc = 4'h1;
                4, 5:    opc = 4'h2;
                6:       opc = 4'hE;
                7:       opc = 4'hF;
                default: opc = 4'($urandom_range(3, 13));
            endcase
            rst = (opc != 4'hF) && ($urandom_range(0, 9) == 0);
            run_instr(opc, rst);
        end

        #3;
        check("scoreboard_drained", 12'(sb.size()), 12'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
